// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential divider.
// Ports (master = controller, slave = divider):
//   start, dividend, divisor              : controller -> divider
//   quotient, remainder, busy, done,
//   div_by_zero                           : divider -> controller
interface seq_divider_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one conditional subtract per clock,
// WIDTH iterations per division, single WIDTH+1-bit subtract stage.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_divider_if.slave (start/operands in; quotient, remainder,
//            busy, done, div_by_zero out, all registered)
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial;
    logic [SUM_W-1:0] sum;
    logic             no_borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, iteration datapath and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        // T - {0,divisor} as T + ~{0,divisor} + 1; the top sum bit is the carry
        trial     = {r_q, q_q[WIDTH-1]};
        sum       = SUM_W'({1'b0, trial}) + SUM_W'({1'b0, ~{1'b0, dvs_q}}) + SUM_W'(1);
        // R < divisor keeps the difference below 2^WIDTH whenever there is no
        // borrow, so bit WIDTH is zero there; including it keeps the test exact.
        no_borrow = sum[SUM_W-1] & ~sum[WIDTH];
        r_next    = no_borrow ? sum[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next    = {q_q[WIDTH-2:0], no_borrow};

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvs_d = bus.divisor;
                    r_d   = '0;
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(WIDTH);
                        q_d     = bus.dividend;
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = q_next;
                    rem_d   = r_next;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule
